// File: rtl/seq_sched_pkg.sv
// Shared types, default sizes and helpers for the sequence-detector sequencer.
package seq_sched_pkg;

  localparam int unsigned DefWordW = 8;
  localparam int unsigned DefCntW  = 4;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClr   = 3'd1,
    StShift = 3'd2,
    StDrain = 3'd3,
    StDone  = 3'd4
  } state_e;

  // Increment when inc is set, holding at max_val instead of wrapping.
  function automatic int unsigned sat_inc(input int unsigned val, input logic inc,
                                          input int unsigned max_val);
    if (inc && (val < max_val)) begin
      return val + 1;
    end
    return val;
  endfunction

endpackage

// File: rtl/seq_sched_if.sv
// Word-in / detector / result-out signal bundle of the sequencer.
interface seq_sched_if
  import seq_sched_pkg::*;
#(
  parameter int unsigned WORD_W = DefWordW,
  parameter int unsigned CNT_W  = DefCntW
) ();

  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic              word_ready;
  logic              det_clr;
  logic              det_in;
  logic              det_out;
  logic              res_valid;
  logic              res_ready;
  logic [CNT_W-1:0]  res_count;
  logic              res_hit;

  modport master (
    output word_valid, word_data, det_out, res_ready,
    input  word_ready, det_clr, det_in, res_valid, res_count, res_hit
  );

  modport slave (
    input  word_valid, word_data, det_out, res_ready,
    output word_ready, det_clr, det_in, res_valid, res_count, res_hit
  );

endinterface

// File: rtl/seq_sched_shreg.sv
// Word shift register (MSB first) with bit index counter and last-bit flag.
module seq_sched_shreg #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned IdxW   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_data_i,
  input  logic              load_idx_i,
  input  logic              shift_i,
  input  logic [WORD_W-1:0] data_i,
  output logic              msb_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              last_o
);

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [IdxW-1:0]   idx_q, idx_d;

  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    if (load_data_i) begin
      shreg_d = data_i;
    end else if (shift_i) begin
      shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
    end
    if (load_idx_i) begin
      idx_d = IdxW'(WORD_W - 1);
    end else if (shift_i && (idx_q != '0)) begin
      idx_d = idx_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  assign msb_o  = shreg_q[WORD_W-1];
  assign idx_o  = idx_q;
  assign last_o = (idx_q == '0);

endmodule

// File: rtl/seq_det_sched.sv
// Sequencer feeding words bit-serially into a run detector and counting its hits per word.
// Optional SEQ_SCHED_CONT_EN: only the first word after reset clears the detector.
module seq_det_sched
  import seq_sched_pkg::*;
#(
  parameter int unsigned WORD_W = DefWordW,
  parameter int unsigned CNT_W  = DefCntW
) (
  input logic        clk,
  input logic        reset,
  seq_sched_if.slave bus
);

  localparam int unsigned IdxW   = $clog2(WORD_W);
  localparam int unsigned CntMax = (2 ** CNT_W) - 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             first_q, first_d;
  logic             load_data, load_idx, shift_en, sample_en;
  logic             msb, last;
  logic [IdxW-1:0]  idx;

  seq_sched_shreg #(
    .WORD_W (WORD_W),
    .IdxW   (IdxW)
  ) u_shreg (
    .clk         (clk),
    .reset       (reset),
    .load_data_i (load_data),
    .load_idx_i  (load_idx),
    .shift_i     (shift_en),
    .data_i      (bus.word_data),
    .msb_o       (msb),
    .idx_o       (idx),
    .last_o      (last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      count_q <= '0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    first_d   = first_q;
    load_data = 1'b0;
    load_idx  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.word_valid) begin
          load_data = 1'b1;
`ifdef SEQ_SCHED_CONT_EN
          if (first_q) begin
            state_d = StClr;
          end else begin
            load_idx = 1'b1;
            state_d  = StShift;
          end
`else
          state_d = StClr;
`endif
        end
      end
      StClr: begin
        load_idx = 1'b1;
        first_d  = 1'b0;
        state_d  = StShift;
      end
      StShift: if (last) state_d = StDrain;
      StDrain: state_d = StDone;
      StDone:  if (bus.res_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // The detector answers one cycle late, so the first SHIFT cycle has nothing to sample.
  assign shift_en  = (state_q == StShift);
  assign sample_en = (shift_en && (idx != IdxW'(WORD_W - 1))) || (state_q == StDrain);

  always_comb begin
    count_d = count_q;
    if ((state_q == StIdle) && bus.word_valid) begin
      count_d = '0;
    end else if (sample_en) begin
      count_d = CNT_W'(sat_inc(32'(count_q), bus.det_out, CntMax));
    end
  end

  always_comb begin
    bus.word_ready = (state_q == StIdle);
    bus.res_valid  = (state_q == StDone);
    bus.det_in     = shift_en & msb;
    bus.det_clr    = (state_q == StClr) | ~reset;
    bus.res_count  = count_q;
    bus.res_hit    = (count_q != '0);
  end

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed + random bench for seq_det_sched with a run-of-four detector model attached.
module tb_seq_det_sched;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   cyc;
  int   n_word_hs;
  int   n_res_hs;
  bit   fresh;
  bit   cont;

  seq_sched_if #(.WORD_W(8), .CNT_W(4)) bus_a ();
  seq_sched_if #(.WORD_W(8), .CNT_W(2)) bus_b ();

  seq_det_sched #(.WORD_W(8), .CNT_W(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  seq_det_sched #(.WORD_W(8), .CNT_W(2)) u_dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Detector: out high once the last four bits seen are equal; cleared by det_clr.
  int   run_a, run_b;
  logic prev_a, prev_b;

  always_ff @(posedge clk) begin
    if (bus_a.det_clr) begin
      run_a <= 0;
    end else if (run_a == 0 || bus_a.det_in != prev_a) begin
      run_a  <= 1;
      prev_a <= bus_a.det_in;
    end else if (run_a < 4) begin
      run_a <= run_a + 1;
    end
    if (bus_b.det_clr) begin
      run_b <= 0;
    end else if (run_b == 0 || bus_b.det_in != prev_b) begin
      run_b  <= 1;
      prev_b <= bus_b.det_in;
    end else if (run_b < 4) begin
      run_b <= run_b + 1;
    end
  end

  assign bus_a.det_out = (run_a == 4);
  assign bus_b.det_out = (run_b == 4);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset && bus_a.word_valid && bus_a.word_ready) n_word_hs <= n_word_hs + 1;
    if (reset && bus_a.res_valid && bus_a.res_ready) n_res_hs <= n_res_hs + 1;
  end

  // Reference: scan the word alone, count bit positions ending a run of >= 4 equal bits.
  function automatic int exp_count(input logic [7:0] w, input int maxc);
    int   run;
    int   n;
    logic prev;
    run  = 0;
    n    = 0;
    prev = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      run  = (run != 0 && w[i] == prev) ? run + 1 : 1;
      prev = w[i];
      if (run >= 4 && n < maxc) n++;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Feed one word on bus_a and check the result; returns at the negedge of the DONE cycle.
  task automatic run_word(input logic [7:0] w, input bit keep_valid);
    int c, clr_cyc, nclr, rdy_bad, lat;
    bit seen, got;
    logic [3:0] cnt;
    logic hit;
    bus_a.word_data  = w;
    bus_a.word_valid = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = bus_a.word_ready;
    end
    if (!seen) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    c = cyc;
    @(posedge clk);
    #1;
    if (!keep_valid) bus_a.word_valid = 1'b0;
    got = 1'b0; nclr = 0; clr_cyc = 0; rdy_bad = 0; lat = 0; cnt = '0; hit = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus_a.det_clr) begin
        nclr++;
        clr_cyc = cyc;
      end
      if (bus_a.word_ready) rdy_bad++;
      if (bus_a.res_valid) begin
        got = 1'b1;
        lat = cyc - c;
        cnt = bus_a.res_count;
        hit = bus_a.res_hit;
      end
    end
    if (!got) begin
      check("res_timeout", 32'd0, 32'd1);
      return;
    end
    check("latency", lat, (cont && !fresh) ? 11 - 1 : 11);
    check("det_clr_cycles", nclr, (cont && !fresh) ? 0 : 1);
    if (!cont || fresh) begin
      check("det_clr_at_c1", clr_cyc - c, 1);
      check("res_count", 32'(cnt), exp_count(w, 15));
      check("res_hit", 32'(hit), 32'(exp_count(w, 15) != 0));
    end
    check("ready_low_busy", rdy_bad, 0);
    fresh = 1'b0;
  endtask

  initial begin
    int   base_w, base_r, bad;
    bit   got;
`ifdef SEQ_SCHED_CONT_EN
    cont = 1'b1;
`else
    cont = 1'b0;
`endif
    errors = 0; checks = 0; cyc = 0; n_word_hs = 0; n_res_hs = 0; fresh = 1'b1;
    bus_a.word_valid = 1'b0; bus_a.word_data = '0; bus_a.res_ready = 1'b1;
    bus_b.word_valid = 1'b0; bus_b.word_data = '0; bus_b.res_ready = 1'b1;
    reset = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_word_ready", bus_a.word_ready, 1);
    check("rst_res_valid", bus_a.res_valid, 0);
    check("rst_det_in", bus_a.det_in, 0);
    check("rst_det_clr", bus_a.det_clr, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // 1: reset mid-SHIFT aborts the word
    bus_a.word_data  = 8'h00;
    bus_a.word_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_a.word_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_det_clr", bus_a.det_clr, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    fresh = 1'b1;
    @(negedge clk);
    check("abort_word_ready", bus_a.word_ready, 1);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus_a.res_valid) bad++;
    end
    check("abort_no_result", bad, 0);
    @(posedge clk);
    #1;

    // 2, 3: single word, then two back-to-back
    run_word(8'h00, 1'b0);
    run_word(8'hF0, 1'b0);
    run_word(8'hAA, 1'b0);

    // 4: saturating count on the narrow instance, result held while res_ready is low
    bus_b.res_ready  = 1'b0;
    bus_b.word_data  = 8'hFF;
    bus_b.word_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_b.word_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = bus_b.res_valid;
    end
    check("sat_res_seen", got, 1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (!bus_b.res_valid || bus_b.res_count !== 2'(exp_count(8'hFF, 3)) || !bus_b.res_hit)
        bad++;
      @(negedge clk);
    end
    check("sat_count", bus_b.res_count, exp_count(8'hFF, 3));
    check("sat_stable", bad, 0);
    bus_b.res_ready = 1'b1;
    @(negedge clk);
    check("sat_released", bus_b.res_valid, 0);
    @(posedge clk);
    #1;

    // 5: identical words in a row
    run_word(8'hFF, 1'b0);
    run_word(8'hFF, 1'b0);

    // 6: word_valid held high across several words
    @(posedge clk);
    #1;
    base_w = n_word_hs;
    base_r = n_res_hs;
    run_word(8'h00, 1'b1);
    run_word(8'hF0, 1'b1);
    run_word(8'h81, 1'b0);
    @(posedge clk);
    #1;
    check("held_words", n_word_hs - base_w, 3);
    check("held_results", n_res_hs - base_r, 3);

    // Random words with random idle gaps
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      run_word(8'($urandom_range(0, 255)), 1'b0);
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
